// File: rtl/fruta_gen.sv
// Fruit placement: picks a pseudo-random empty tile of the map on request,
// falling back to a row-major scan, and flags a full board.
module fruta_gen #(
  parameter int unsigned MAPA_WIDTH  = 40,
  parameter int unsigned MAPA_HEIGHT = 30,
  parameter int unsigned X_BITS      = 6,
  parameter int unsigned Y_BITS      = 5,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned MAX_TRIES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fruta_req,
  output logic       fruta_valid,
  output logic [9:0] fruta_x,
  output logic [9:0] fruta_y,
  output logic       map_full,
  output logic       busy,
  output logic       map_renable,
  output logic [9:0] map_rx,
  output logic [9:0] map_ry,
  input  logic [1:0] map_rdata
);

  localparam int unsigned CW = 10;
  localparam int unsigned TW = 8;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW:0]   W_LIM   = 11'(MAPA_WIDTH);
  localparam logic [CW:0]   H_LIM   = 11'(MAPA_HEIGHT);
  localparam logic [CW-1:0] X_LAST  = 10'(MAPA_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = 10'(MAPA_HEIGHT - 1);
  localparam logic [TW-1:0] TRY_LIM = 8'(MAX_TRIES);
  localparam logic [CW-1:0] RST_POS = 10'd13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PICK,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_SCAN_INIT,
    S_SREAD,
    S_SWAIT,
    S_SCHECK,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr, lfsr_nxt;
  logic [TW-1:0] tries, tries_nxt, tries_inc;
  logic [CW-1:0] cand_x, cand_x_nxt, cand_y, cand_y_nxt;
  logic [CW-1:0] sx, sx_nxt, sy, sy_nxt;
  logic [CW-1:0] fruta_x_nxt, fruta_y_nxt;
  logic [CW-1:0] map_rx_nxt, map_ry_nxt;
  logic          map_full_nxt, fruta_valid_nxt, busy_nxt, map_renable_nxt;
  logic [CW-1:0] cx, cy;
  logic          cand_out;
  logic          cell_empty;
  logic          scan_last;
  logic [CW-1:0] sx_adv, sy_adv;

  // Register stage: state, LFSR, counters and all outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_INIT;
      tries       <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      sx          <= '0;
      sy          <= '0;
      fruta_x     <= RST_POS;
      fruta_y     <= RST_POS;
      map_full    <= 1'b0;
      fruta_valid <= 1'b0;
      busy        <= 1'b0;
      map_renable <= 1'b0;
      map_rx      <= '0;
      map_ry      <= '0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      tries       <= tries_nxt;
      cand_x      <= cand_x_nxt;
      cand_y      <= cand_y_nxt;
      sx          <= sx_nxt;
      sy          <= sy_nxt;
      fruta_x     <= fruta_x_nxt;
      fruta_y     <= fruta_y_nxt;
      map_full    <= map_full_nxt;
      fruta_valid <= fruta_valid_nxt;
      busy        <= busy_nxt;
      map_renable <= map_renable_nxt;
      map_rx      <= map_rx_nxt;
      map_ry      <= map_ry_nxt;
    end
  end

  // Free-running Galois LFSR and candidate/scan helper terms.
  always_comb begin
    lfsr_nxt   = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    cx         = 10'(lfsr[X_BITS-1:0]);
    cy         = 10'(lfsr[8+Y_BITS-1:8]);
    cand_out   = ({1'b0, cx} >= W_LIM) || ({1'b0, cy} >= H_LIM);
    cell_empty = (map_rdata == 2'b00);
    tries_inc  = tries + 8'd1;
    scan_last  = (sx == X_LAST) && (sy == Y_LAST);
    sx_adv     = (sx == X_LAST) ? '0 : sx + 10'd1;
    sy_adv     = (sx == X_LAST) ? sy + 10'd1 : sy;
  end

  // Next-state and next-output logic; outputs are registered from the next state
  // so busy/renable/valid line up with the state they describe.
  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    cand_x_nxt   = cand_x;
    cand_y_nxt   = cand_y;
    sx_nxt       = sx;
    sy_nxt       = sy;
    fruta_x_nxt  = fruta_x;
    fruta_y_nxt  = fruta_y;
    map_full_nxt = map_full;
    map_rx_nxt   = map_rx;
    map_ry_nxt   = map_ry;

    case (state)
      S_IDLE: begin
        if (fruta_req) begin
          state_nxt = S_PICK;
          tries_nxt = '0;
        end
      end
      S_PICK: begin
        cand_x_nxt = cx;
        cand_y_nxt = cy;
        if (cand_out) begin
          tries_nxt = tries_inc;
          state_nxt = (tries_inc == TRY_LIM) ? S_SCAN_INIT : S_PICK;
        end else begin
          state_nxt  = S_READ;
          map_rx_nxt = cx;
          map_ry_nxt = cy;
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (cell_empty) begin
          state_nxt    = S_DONE;
          fruta_x_nxt  = cand_x;
          fruta_y_nxt  = cand_y;
          map_full_nxt = 1'b0;
        end else begin
          tries_nxt = tries_inc;
          state_nxt = (tries_inc == TRY_LIM) ? S_SCAN_INIT : S_PICK;
        end
      end
      S_SCAN_INIT: begin
        sx_nxt     = '0;
        sy_nxt     = '0;
        map_rx_nxt = '0;
        map_ry_nxt = '0;
        state_nxt  = S_SREAD;
      end
      S_SREAD: state_nxt = S_SWAIT;
      S_SWAIT: state_nxt = S_SCHECK;
      S_SCHECK: begin
        if (cell_empty) begin
          state_nxt    = S_DONE;
          fruta_x_nxt  = sx;
          fruta_y_nxt  = sy;
          map_full_nxt = 1'b0;
        end else if (scan_last) begin
          // Whole board occupied: keep the old coordinates, flag full.
          state_nxt    = S_DONE;
          map_full_nxt = 1'b1;
        end else begin
          sx_nxt     = sx_adv;
          sy_nxt     = sy_adv;
          map_rx_nxt = sx_adv;
          map_ry_nxt = sy_adv;
          state_nxt  = S_SREAD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt        = (state_nxt != S_IDLE);
    map_renable_nxt = (state_nxt == S_READ) || (state_nxt == S_SREAD);
    fruta_valid_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_fruta_gen.sv
// Self-checking bench for fruta_gen with a tile-map RAM model and a
// rule-based outcome model (which cells are acceptable answers).
module tb_fruta_gen;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int BOUND = 64 * 4 + 1 + 3 * W * H + 2;

  logic       clk;
  logic       reset;
  logic       fruta_req;
  logic       fruta_valid;
  logic [9:0] fruta_x;
  logic [9:0] fruta_y;
  logic       map_full;
  logic       busy;
  logic       map_renable;
  logic [9:0] map_rx;
  logic [9:0] map_ry;
  logic [1:0] map_rdata;

  fruta_gen dut (
    .clk         (clk),
    .reset       (reset),
    .fruta_req   (fruta_req),
    .fruta_valid (fruta_valid),
    .fruta_x     (fruta_x),
    .fruta_y     (fruta_y),
    .map_full    (map_full),
    .busy        (busy),
    .map_renable (map_renable),
    .map_rx      (map_rx),
    .map_ry      (map_ry),
    .map_rdata   (map_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mem [0:H-1][0:W-1];
  logic       ren_q;
  logic [9:0] rx_q, ry_q;

  int n_cmp = 0;
  int n_err = 0;
  int exp_x = 13;
  int exp_y = 13;
  int valid_cnt = 0;
  int proto_viol = 0;
  int cyc = 0;
  int last_ren = -10;

  // Registered-address RAM: data for a read issued in cycle N is on map_rdata in N+2.
  // Any other cycle returns "fruit" so a mistimed sample is visible.
  always @(posedge clk) begin
    ren_q <= map_renable;
    rx_q  <= map_rx;
    ry_q  <= map_ry;
    if (ren_q && int'(rx_q) < W && int'(ry_q) < H)
      map_rdata <= mem[int'(ry_q)][int'(rx_q)];
    else
      map_rdata <= 2'b10;
  end

  // Bookkeeping of valid pulses and read-strobe legality.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fruta_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (map_renable === 1'b1) begin
      if (cyc - last_ren < 3 || busy !== 1'b1 || int'(map_rx) >= W || int'(map_ry) >= H)
        proto_viol <= proto_viol + 1;
      last_ren <= cyc;
    end
  end

  task automatic fill_all(input logic [1:0] v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mem[y][x] = v;
  endtask

  // Issue one request from IDLE and wait for the valid pulse; lat counts cycles
  // from the request cycle to the DONE cycle inclusive.
  task automatic do_request(input int limit, output int lat, output bit got, output logic busy_seen);
    got = 1'b0;
    @(negedge clk);
    fruta_req = 1'b1;
    @(negedge clk);
    fruta_req = 1'b0;
    lat = 2;
    busy_seen = busy;
    if (fruta_valid === 1'b1) got = 1'b1;
    while (!got && lat < limit) begin
      @(negedge clk);
      lat++;
      if (fruta_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fruta_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({fruta_x, fruta_y} !== {10'd13, 10'd13}) begin
      n_err++; $display("FAIL reset_pos: got (%0d,%0d) want (13,13)", fruta_x, fruta_y);
    end
    n_cmp++;
    if ({fruta_valid, busy, map_full, map_renable} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: valid/busy/full/ren got %b want 0000",
                        {fruta_valid, busy, map_full, map_renable});
    end
    exp_x = 13; exp_y = 13;
  endtask

  task automatic test_empty_map();
    int lat; bit got; logic bs;
    fill_all(2'b00);
    do_request(300, lat, got, bs);
    n_cmp++;
    if (bs !== 1'b1) begin n_err++; $display("FAIL empty_busy: got %b want 1", bs); end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL empty_timeout: no valid after %0d cycles, want <= %0d", lat, 4 * 64 + 2);
    end else begin
      n_cmp++;
      if (lat < 6 || lat > 4 * 64 + 2) begin
        n_err++; $display("FAIL empty_latency: got %0d want 6..%0d", lat, 4 * 64 + 2);
      end
      n_cmp++;
      if (int'(fruta_x) >= W || int'(fruta_y) >= H || map_full !== 1'b0) begin
        n_err++; $display("FAIL empty_result: got (%0d,%0d) full=%b want in-map, full=0",
                          fruta_x, fruta_y, map_full);
      end
      exp_x = int'(fruta_x); exp_y = int'(fruta_y);
    end
    @(negedge clk);
    n_cmp++;
    if ({fruta_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL empty_after: valid/busy got %b want 00", {fruta_valid, busy});
    end
  endtask

  task automatic test_last_cell();
    int lat; bit got; logic bs;
    fill_all(2'b01);
    mem[H-1][W-1] = 2'b00;
    do_request(BOUND + 8, lat, got, bs);
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL last_timeout: no valid in %0d cycles", lat);
    end else begin
      n_cmp++;
      if (int'(fruta_x) != W - 1 || int'(fruta_y) != H - 1 || map_full !== 1'b0) begin
        n_err++; $display("FAIL last_result: got (%0d,%0d) full=%b want (%0d,%0d) full=0",
                          fruta_x, fruta_y, map_full, W - 1, H - 1);
      end
      n_cmp++;
      if (lat > BOUND) begin n_err++; $display("FAIL last_latency: got %0d want <= %0d", lat, BOUND); end
      exp_x = W - 1; exp_y = H - 1;
    end
  endtask

  task automatic test_full_board();
    int lat; bit got; logic bs;
    fill_all(2'b11);
    mem[7][5] = 2'b00;
    do_request(BOUND + 8, lat, got, bs);
    n_cmp++;
    if (!got || fruta_x !== 10'd5 || fruta_y !== 10'd7 || map_full !== 1'b0) begin
      n_err++; $display("FAIL prior_fruit: got=%0b (%0d,%0d) full=%b want (5,7) full=0",
                        got, fruta_x, fruta_y, map_full);
    end
    exp_x = 5; exp_y = 7;
    fill_all(2'b11);
    do_request(BOUND + 8, lat, got, bs);
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL full_timeout: no valid in %0d cycles", lat);
    end else begin
      n_cmp++;
      if (map_full !== 1'b1 || fruta_x !== 10'd5 || fruta_y !== 10'd7) begin
        n_err++; $display("FAIL full_result: got (%0d,%0d) full=%b want (5,7) full=1",
                          fruta_x, fruta_y, map_full);
      end
      n_cmp++;
      if (lat > BOUND) begin n_err++; $display("FAIL full_latency: got %0d want <= %0d", lat, BOUND); end
      @(negedge clk);
      n_cmp++;
      if ({busy, fruta_valid, map_full} !== 3'b001) begin
        n_err++; $display("FAIL full_after: busy/valid/full got %b want 001", {busy, fruta_valid, map_full});
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0; int n; bit got;
    fill_all(2'b00);
    v0 = valid_cnt;
    got = 1'b0;
    @(negedge clk); fruta_req = 1'b1;
    @(negedge clk); fruta_req = 1'b0;
    @(negedge clk); fruta_req = 1'b1;
    @(negedge clk); fruta_req = 1'b0;
    n = 0;
    if (fruta_valid === 1'b1) got = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk); n++;
      if (fruta_valid === 1'b1) got = 1'b1;
    end
    // Request raised during the DONE cycle must be dropped.
    fruta_req = 1'b1;
    @(negedge clk);
    fruta_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_req: busy got %b want 0", busy); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (valid_cnt - v0 != 1) begin
      n_err++; $display("FAIL b2b_pulses: got %0d valid pulses want 1", valid_cnt - v0);
    end
    if (got) begin exp_x = int'(fruta_x); exp_y = int'(fruta_y); end
  endtask

  task automatic test_reset_in_wait();
    int n; int v0; int lat; bit got; logic bs;
    fill_all(2'b00);
    @(negedge clk); fruta_req = 1'b1;
    @(negedge clk); fruta_req = 1'b0;
    n = 0;
    while (map_renable !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (map_renable !== 1'b1) begin n_err++; $display("FAIL rst_wait_read: no read strobe seen"); end
    @(negedge clk);
    reset = 1'b0;
    v0 = valid_cnt;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++;
    if ({busy, map_renable, fruta_valid} !== 3'b000 || fruta_x !== 10'd13 || fruta_y !== 10'd13) begin
      n_err++; $display("FAIL rst_wait_state: busy/ren/valid=%b pos=(%0d,%0d) want 000 (13,13)",
                        {busy, map_renable, fruta_valid}, fruta_x, fruta_y);
    end
    exp_x = 13; exp_y = 13;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (valid_cnt != v0) begin n_err++; $display("FAIL rst_wait_pulse: got %0d pulses want 0", valid_cnt - v0); end
    do_request(300, lat, got, bs);
    n_cmp++;
    if (!got || int'(fruta_x) >= W || int'(fruta_y) >= H || map_full !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_fresh: got=%0b (%0d,%0d) full=%b want in-map full=0",
                        got, fruta_x, fruta_y, map_full);
    end
    if (got) begin exp_x = int'(fruta_x); exp_y = int'(fruta_y); end
  endtask

  // Random maps; acceptable answer derived from the count/location of empty cells.
  task automatic test_random(input int iters);
    int mode; int n_empty; int ex; int ey; int lat; bit got; logic bs; int rx; int ry;
    for (int it = 0; it < iters; it++) begin
      mode = $urandom_range(0, 3);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          if (mode == 0 && $urandom_range(0, 1) == 0) mem[y][x] = 2'b00;
          else if (mode == 1 && $urandom_range(0, 31) == 0) mem[y][x] = 2'b00;
          else mem[y][x] = 2'($urandom_range(1, 3));
        end
      if (mode == 2) mem[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 2'b00;
      n_empty = 0; ex = 0; ey = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (mem[y][x] == 2'b00) begin n_empty++; ex = x; ey = y; end
      repeat ($urandom_range(0, 7)) @(negedge clk);
      do_request(BOUND + 8, lat, got, bs);
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL rand%0d_timeout: no valid in %0d cycles", it, lat);
        continue;
      end
      n_cmp++;
      if (lat > BOUND || map_full !== (n_empty == 0)) begin
        n_err++; $display("FAIL rand%0d_lat_full: lat=%0d full=%b want lat<=%0d full=%b",
                          it, lat, map_full, BOUND, n_empty == 0);
      end
      rx = int'(fruta_x); ry = int'(fruta_y);
      n_cmp++;
      if (n_empty == 0) begin
        if (rx != exp_x || ry != exp_y) begin
          n_err++; $display("FAIL rand%0d_held: got (%0d,%0d) want (%0d,%0d)", it, rx, ry, exp_x, exp_y);
        end
      end else if (n_empty == 1) begin
        if (rx != ex || ry != ey) begin
          n_err++; $display("FAIL rand%0d_single: got (%0d,%0d) want (%0d,%0d)", it, rx, ry, ex, ey);
        end
      end else if (rx >= W || ry >= H) begin
        n_err++; $display("FAIL rand%0d_range: got (%0d,%0d) want inside %0dx%0d", it, rx, ry, W, H);
      end else if (mem[ry][rx] != 2'b00) begin
        n_err++; $display("FAIL rand%0d_occupied: got (%0d,%0d) cell=%b want 00", it, rx, ry, mem[ry][rx]);
      end
      if (n_empty != 0) begin exp_x = rx; exp_y = ry; end
    end
  endtask

  task automatic test_read_protocol();
    n_cmp++;
    if (proto_viol != 0) begin
      n_err++; $display("FAIL read_protocol: got %0d bad read strobes want 0", proto_viol);
    end
  endtask

  initial begin
    reset = 1'b0;
    fruta_req = 1'b0;
    fill_all(2'b00);
    test_reset();
    test_empty_map();
    test_last_cell();
    test_full_board();
    test_back_to_back();
    test_reset_in_wait();
    test_random(8);
    test_read_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fruta_gen.md
Name: fruta_gen

Overview:
- Fruit-placement stage directly upstream of the game update engine. On a request it picks a pseudo-random empty cell of the MAPA_WIDTH x MAPA_HEIGHT tile map and returns its coordinates with a one-cycle valid pulse.
- Emptiness is checked through a read port on the tile map RAM.
- If random tries are exhausted, it falls back to a deterministic row-major scan. It flags a full board instead of hanging.

Parameters:
- MAPA_WIDTH, 40, map columns (max 1024)
- MAPA_HEIGHT, 30, map rows (max 1024)
- X_BITS, 6, LFSR bits used for the x candidate; 2^X_BITS >= MAPA_WIDTH
- Y_BITS, 5, LFSR bits used for the y candidate; 2^Y_BITS >= MAPA_HEIGHT
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001
- MAX_TRIES, 64, random candidates (1..127) before scan fallback

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- fruta_req  in  1  request pulse for a new fruit position
- fruta_valid  out  1  one-cycle pulse: fruta_x/fruta_y/map_full updated
- fruta_x  out  10  fruit column
- fruta_y  out  10  fruit row
- map_full  out  1  1 = no empty cell found on last request
- busy  out  1  1 in every state except IDLE
- map_renable  out  1  map read strobe
- map_rx  out  10  map read column
- map_ry  out  10  map read row
- map_rdata  in  2  cell contents: 00 empty, 01 snake, 10 fruit, 11 obstacle

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, fruta_x=13, fruta_y=13, fruta_valid=0, map_full=0, busy=0, map_renable=0, map_rx=0, map_ry=0, try counter=0, lfsr=SEED.
  - Reset aborts any operation in progress. No valid pulse is produced for the aborted request.
- LFSR: 16-bit Galois, polynomial mask 16'hB400, shifts right every cycle when not in reset, including IDLE (free-running, so player timing adds entropy). It is never zero.
- Candidate: cx = lfsr[X_BITS-1:0], cy = lfsr[8+Y_BITS-1:8], zero-extended to 10 bits.
- Map read timing: address and renable are driven in cycle N; map_rdata is valid and sampled in cycle N+2 (registered-address synchronous RAM).
- map_renable is high only in READ/SREAD states; otherwise 0.
- FSM:
  - IDLE: if fruta_req=1 -> PICK, try counter=0, map_full cleared internally. Otherwise stay.
  - PICK: latch cx/cy.
    - If cx>=MAPA_WIDTH or cy>=MAPA_HEIGHT: count a try and stay in PICK (1 cycle/reject).
    - Else -> READ.
    - When the try counter reaches MAX_TRIES -> SCAN_INIT.
  - READ: map_rx=cx, map_ry=cy, map_renable=1 -> WAIT.
  - WAIT: -> CHECK.
  - CHECK: if map_rdata==00 -> DONE with the candidate. Else count a try; -> PICK, or -> SCAN_INIT when count==MAX_TRIES.
  - SCAN_INIT: sx=0, sy=0 -> SREAD.
  - SREAD: map_rx=sx, map_ry=sy, map_renable=1 -> SWAIT.
  - SWAIT: -> SCHECK.
  - SCHECK: if map_rdata==00 -> DONE with (sx,sy).
    - Else advance row-major: sx+1; at MAPA_WIDTH wrap sx=0 and sy+1.
    - If (sx,sy) was (MAPA_WIDTH-1, MAPA_HEIGHT-1) -> DONE with full=1. Else -> SREAD.
  - DONE: fruta_valid=1 for exactly this cycle -> IDLE.
    - Not full: fruta_x/fruta_y load the found cell, map_full=0.
    - Full: fruta_x/fruta_y hold their previous values, map_full=1.
- fruta_x/fruta_y/map_full change only in DONE or on reset, and are stable between valid pulses.
- fruta_req is ignored while busy=1, including in DONE. A req in the first IDLE cycle after DONE is accepted.
- Latency:
  - Best case, req to valid: 6 cycles (IDLE, PICK, READ, WAIT, CHECK, DONE).
  - Worst case is bounded: MAX_TRIES x 4 + 1 + 3 x MAPA_WIDTH x MAPA_HEIGHT + 2 cycles.
- The block never writes the map. The consumer paints the fruit after fruta_valid.

Test Plan:
- Hold reset low 3 cycles then release -> fruta_x=13, fruta_y=13, fruta_valid=0, busy=0, map_full=0, map_renable=0.
- All-empty map model; pulse fruta_req -> busy next cycle; fruta_valid within 6..(4*64+2) cycles; fruta_x<40, fruta_y<30. Every map_renable is followed 2 cycles later by a sample.
- Map all 01 except cell (39,29)=00, MAX_TRIES=64 -> scan reached; fruta_valid with fruta_x=39, fruta_y=29, map_full=0.
- Map all 11 after a prior fruit at (5,7) -> fruta_valid with map_full=1, fruta_x=5, fruta_y=7 unchanged; busy drops the cycle after.
- Pulse fruta_req again 2 cycles after the first, and on the DONE cycle -> exactly one fruta_valid per accepted request; the second req is ignored.
- Assert reset during WAIT -> next cycle IDLE, map_renable=0, no fruta_valid. A fresh req then completes normally.
